huffman_frame_ctrl: RTL and testbench
=====================================

HUFFMAN_FRAME_CTRL -- requirements
Module: huffman_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 100, meaning the number of gray symbols per frame sent to the huffman core.
REQ-002 The block SHALL have parameter RST_CYC, default 2, meaning the number of cycles core_rst is held high before each frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports req0 and req1, input, 1 bit each: requester i has a frame pending.
REQ-006 The block SHALL have ports sym_valid0 and sym_valid1, input, 1 bit each: requester i symbol strobe.
REQ-007 The block SHALL have ports sym_data0 and sym_data1, input, 8 bits each: requester i gray symbol.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: requester i owns the core (one-hot or zero).
REQ-009 The block SHALL have port core_rst, output, 1 bit: reset to the huffman core.
REQ-010 The block SHALL have ports gray_valid (output, 1 bit) and gray_data (output, 8 bits): the symbol stream to the core.
REQ-011 The block SHALL have ports CNT_valid and code_valid, input, 1 bit each: the core's status pulses.
REQ-012 The block SHALL have ports busy (1 bit), done (1 bit) and done_id (1 bit), all outputs: frame in progress, completion pulse, and the requester that completed.
REQ-013 The block SHALL have port err, output, 1 bit: timeout pulse.

Function
REQ-014 FSM states SHALL be IDLE, CLR, STREAM, WAIT_CNT, WAIT_CODE and DONE, all registered.
- Reset value of every output is 0, except core_rst, which is 1.
REQ-015 IDLE SHALL behave as follows:
- If any req is high, go to CLR and register the grant.
- If both req0 and req1 are high, grant the requester not served last; the last-served pointer resets to requester 1, so requester 0 wins the first tie.
REQ-016 CLR SHALL hold core_rst high for exactly RST_CYC cycles, with gnt held, then go to STREAM with core_rst low.
REQ-017 In STREAM, the selected requester's valid and data SHALL be registered onto gray_valid and gray_data with 1-cycle latency.
- The non-granted requester's inputs are ignored.
- Any sym_valid while its gnt is low is ignored.
REQ-018 A 7-bit symbol counter SHALL increment on each accepted symbol.
- On the FRAME_LEN-th symbol: the counter clears, gnt drops at the next edge, and the FSM goes to WAIT_CNT.
- Exactly FRAME_LEN gray_valid pulses are issued per frame.
REQ-019 WAIT_CNT SHALL go to WAIT_CODE on CNT_valid; a code_valid seen in WAIT_CNT is ignored.
REQ-020 WAIT_CODE SHALL go to DONE on code_valid; a CNT_valid seen in WAIT_CODE is ignored.
REQ-021 DONE SHALL pulse done for one cycle with done_id equal to the served requester, update the last-served pointer, and return to IDLE.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 Status inputs (CNT_valid, code_valid) arriving in IDLE, CLR or STREAM SHALL be ignored.
REQ-024 A req deasserted after grant SHALL NOT abort the frame; the frame completes only after FRAME_LEN symbols.
REQ-025 A new grant SHALL NOT be issued before done of the current frame; back-to-back frames have a minimum gap of 1 IDLE cycle.

Reset
REQ-026 Asserting reset, including mid-frame, SHALL asynchronously force the following:
- state to IDLE and the counters to 0;
- gnt, gray_valid, done and err to 0;
- core_rst to 1, held for RST_CYC cycles after reset release;
- the last-served pointer to 1.
REQ-027 No partial frame SHALL be resumed after reset.

Configuration
REQ-028 With macro HUF_TIMEOUT_EN defined, the block SHALL include an 8-bit watchdog.
- The watchdog clears on entry to WAIT_CNT or WAIT_CODE and counts each cycle in those states.
- At 255 it pulses err for 1 cycle, sets done_id to the served requester, does not assert done, and goes to IDLE.
- The next frame then passes through CLR as normal.
REQ-029 Without HUF_TIMEOUT_EN, the block SHALL have no watchdog logic, tie err to 0, and wait indefinitely in WAIT_CNT and WAIT_CODE.

Verification
REQ-030 The bench SHALL cover: req0 only, 100 symbols, CNT_valid then code_valid 5 cycles later -> gnt0=1, core_rst 2 cycles, 100 gray_valid, done=1, done_id=0.
REQ-031 The bench SHALL cover: req0 and req1 high together from reset -> frames served 0,1,0,1 in alternation, with done_id matching each frame.
REQ-032 The bench SHALL cover: a requester sending 105 valids while granted -> exactly 100 gray_valid pulses forwarded, 5 ignored.
REQ-033 The bench SHALL cover: code_valid injected in WAIT_CNT before CNT_valid -> no done until a later code_valid in WAIT_CODE.
REQ-034 The bench SHALL cover: reset asserted at symbol 50 -> all outputs 0 immediately, core_rst=1, then a fresh frame of 100 symbols.
REQ-035 The bench SHALL cover, with HUF_TIMEOUT_EN defined: CNT_valid withheld -> err pulses 255 cycles after entering WAIT_CNT, done stays 0, state returns to IDLE.

Source files
------------

// File: rtl/huffman_frame_ctrl.sv
// Arbitrates two gray-symbol requesters onto one huffman core, framing FRAME_LEN symbols per grant.
// Optional watchdog on the core status waits is built only when HUF_TIMEOUT_EN is defined.
module huffman_frame_ctrl #(
  parameter int FRAME_LEN = 100,
  parameter int RST_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       sym_valid0,
  input  logic       sym_valid1,
  input  logic [7:0] sym_data0,
  input  logic [7:0] sym_data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       core_rst,
  output logic       gray_valid,
  output logic [7:0] gray_data,
  input  logic       CNT_valid,
  input  logic       code_valid,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       err
);

  // state     | meaning
  // IDLE      | no frame; arbitrate pending requests
  // CLR       | core_rst held for RST_CYC cycles, grant held
  // STREAM    | forward granted requester's symbols to the core
  // WAIT_CNT  | wait for the core's CNT_valid
  // WAIT_CODE | wait for the core's code_valid
  // DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, CLR, STREAM, WAIT_CNT, WAIT_CODE, DONE} state_t;

  localparam logic [6:0] LP_LAST_SYM = 7'(FRAME_LEN - 1);
  localparam logic [7:0] LP_RST_LOAD = 8'(RST_CYC - 1);
  localparam logic [7:0] LP_RST_INIT = 8'(RST_CYC);

  state_t     r_state;
  logic       r_gnt0, r_gnt1, r_core_rst, r_gray_valid, r_busy, r_done, r_done_id;
  logic [7:0] r_gray_data;
  logic       r_sel, r_last;
  logic [6:0] r_sym_cnt;
  logic [7:0] r_rst_cnt;

  logic       w_pick1, w_sel_valid;
  logic [7:0] w_sel_data;

  // On a tie, requester 1 wins only if requester 0 was served last.
  assign w_pick1     = req1 & (~req0 | ~r_last);
  assign w_sel_valid = r_sel ? sym_valid1 : sym_valid0;
  assign w_sel_data  = r_sel ? sym_data1 : sym_data0;

`ifdef HUF_TIMEOUT_EN
  logic [7:0] r_wdt;
  logic       r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_core_rst   <= 1'b1;
      r_gray_valid <= 1'b0;
      r_gray_data  <= 8'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_done_id    <= 1'b0;
      r_sel        <= 1'b0;
      r_last       <= 1'b1;
      r_sym_cnt    <= 7'd0;
      r_rst_cnt    <= LP_RST_INIT;
`ifdef HUF_TIMEOUT_EN
      r_wdt        <= 8'h00;
      r_err        <= 1'b0;
`endif
    end else begin
      r_done       <= 1'b0;
      r_gray_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 | req1) begin
            r_state    <= CLR;
            r_sel      <= w_pick1;
            r_gnt0     <= ~w_pick1;
            r_gnt1     <= w_pick1;
            r_core_rst <= 1'b1;
            r_rst_cnt  <= LP_RST_LOAD;
            r_busy     <= 1'b1;
          end else if (r_rst_cnt != 8'd0) begin
            // stretch core_rst for RST_CYC cycles after block reset release
            r_rst_cnt  <= r_rst_cnt - 8'd1;
            r_core_rst <= (r_rst_cnt != 8'd1);
          end
        end
        CLR: begin
          if (r_rst_cnt == 8'd0) begin
            r_state    <= STREAM;
            r_core_rst <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt - 8'd1;
          end
        end
        STREAM: begin
          if (w_sel_valid) begin
            r_gray_valid <= 1'b1;
            r_gray_data  <= w_sel_data;
            if (r_sym_cnt == LP_LAST_SYM) begin
              r_sym_cnt <= 7'd0;
              r_gnt0    <= 1'b0;
              r_gnt1    <= 1'b0;
              r_state   <= WAIT_CNT;
            end else begin
              r_sym_cnt <= r_sym_cnt + 7'd1;
            end
          end
        end
        WAIT_CNT: begin
          if (CNT_valid) r_state <= WAIT_CODE;
        end
        WAIT_CODE: begin
          if (code_valid) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_done_id <= r_sel;
          end
        end
        DONE: begin
          r_last  <= r_sel;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
`ifdef HUF_TIMEOUT_EN
      // Counter is zero on entry to each wait state; value 254 here marks the 255th waiting cycle.
      r_err <= 1'b0;
      if ((r_state == WAIT_CNT && !CNT_valid) || (r_state == WAIT_CODE && !code_valid)) begin
        if (r_wdt == 8'd254) begin
          r_wdt     <= 8'hFF;
          r_err     <= 1'b1;
          r_done_id <= r_sel;
          r_last    <= r_sel;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end else begin
          r_wdt <= r_wdt + 8'd1;
        end
      end else begin
        r_wdt <= 8'h00;
      end
`endif
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign core_rst   = r_core_rst;
  assign gray_valid = r_gray_valid;
  assign gray_data  = r_gray_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign done_id    = r_done_id;

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Directed bench for huffman_frame_ctrl: arbitration, framing, status ordering, reset and timeout.
// Define HUF_TIMEOUT_EN for both bench and RTL to exercise the watchdog path.
module tb_huffman_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       sym_valid0 = 1'b0, sym_valid1 = 1'b0;
  logic [7:0] sym_data0 = 8'h00, sym_data1 = 8'h00;
  logic       CNT_valid = 1'b0, code_valid = 1'b0;
  logic       gnt0, gnt1, core_rst, gray_valid, busy, done, done_id, err;
  logic [7:0] gray_data;

  always #5 clk = ~clk;

  huffman_frame_ctrl #(.FRAME_LEN(100), .RST_CYC(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .sym_valid0(sym_valid0), .sym_valid1(sym_valid1),
    .sym_data0(sym_data0), .sym_data1(sym_data1),
    .gnt0(gnt0), .gnt1(gnt1), .core_rst(core_rst),
    .gray_valid(gray_valid), .gray_data(gray_data),
    .CNT_valid(CNT_valid), .code_valid(code_valid),
    .busy(busy), .done(done), .done_id(done_id), .err(err)
  );

  int n_cmp = 0, n_bad = 0;
  int gv_cnt = 0, gv_sum = 0, crst_cnt = 0, done_cnt = 0, err_cnt = 0, both_gnt = 0;
  int gv_b, sum_b, crst_b, done_b, err_b;

  always @(negedge clk) begin
    if (gray_valid) begin
      gv_cnt = gv_cnt + 1;
      gv_sum = gv_sum + int'(gray_data);
    end
    if (core_rst && (gnt0 || gnt1)) crst_cnt = crst_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
    if (gnt0 && gnt1) both_gnt = both_gnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    gv_b = gv_cnt; sum_b = gv_sum; crst_b = crst_cnt; done_b = done_cnt; err_b = err_cnt;
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int k = 0; k < 40 && id < 0; k++) begin
      if ((gnt0 || gnt1) && !core_rst) id = gnt1 ? 1 : 0;
      else tick(1);
    end
    if (id < 0) chk("grant_timeout", {31'b0, gnt0 | gnt1}, 1);
  endtask

  // granted side sends i = 0..n-1; the other side sends 0xFF noise that must be ignored
  task automatic send(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      sym_valid0 = 1'b1; sym_valid1 = 1'b1;
      if (id == 0) begin sym_data0 = 8'(i); sym_data1 = 8'hFF; end
      else begin sym_data1 = 8'(i); sym_data0 = 8'hFF; end
      tick(1);
    end
    sym_valid0 = 1'b0; sym_valid1 = 1'b0;
  endtask

  task automatic wait_done(input int exp_id, input string tag);
    int k = 0;
    while (!done && k < 30) begin
      tick(1);
      k++;
    end
    chk({tag, "_done"}, {31'b0, done}, 1);
    chk({tag, "_id"}, {31'b0, done_id}, exp_id);
    tick(1);
    chk({tag, "_idle"}, {31'b0, busy}, 0);
  endtask

  task automatic finish_frame(input int exp_id, input string tag);
    CNT_valid = 1'b1; tick(1); CNT_valid = 1'b0;
    tick(4);
    code_valid = 1'b1; tick(1); code_valid = 1'b0;
    wait_done(exp_id, tag);
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_gv_cnt"}, gv_cnt - gv_b, 100);
    chk({tag, "_gv_sum"}, gv_sum - sum_b, 4950);
    chk({tag, "_crst_cyc"}, crst_cnt - crst_b, 2);
    chk({tag, "_done_cnt"}, done_cnt - done_b, 1);
  endtask

  initial begin
    int id;
    int k;
    bit found;

    // reset values and core_rst stretch after release
    tick(3);
    chk("rst_gnt0", {31'b0, gnt0}, 0);
    chk("rst_gnt1", {31'b0, gnt1}, 0);
    chk("rst_core_rst", {31'b0, core_rst}, 1);
    chk("rst_gray_valid", {31'b0, gray_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    reset = 1'b0;
    tick(1);
    chk("crst_hold1", {31'b0, core_rst}, 1);
    tick(1);
    chk("crst_hold2", {31'b0, core_rst}, 0);

    // single requester 0, req dropped after grant
    snap();
    req0 = 1'b1;
    wait_grant(id);
    chk("t1_gnt0", {31'b0, gnt0}, 1);
    chk("t1_gnt1", {31'b0, gnt1}, 0);
    req0 = 1'b0;
    send(0, 100);
    chk("t1_busy_wait", {31'b0, busy}, 1);
    chk("t1_gnt_dropped", {31'b0, gnt0}, 0);
    finish_frame(0, "t1");
    frame_checks("t1");

    // both requesters from reset: alternate 0,1,0,1
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int f = 0; f < 4; f++) begin
      snap();
      wait_grant(id);
      chk("t2_order", id, f % 2);
      send(id, 100);
      finish_frame(f % 2, "t2");
      frame_checks("t2");
    end
    req0 = 1'b0; req1 = 1'b0;

    // 105 valids from requester 1: only 100 forwarded
    snap();
    req1 = 1'b1;
    wait_grant(id);
    chk("t3_gnt1", id, 1);
    req1 = 1'b0;
    send(1, 105);
    finish_frame(1, "t3");
    frame_checks("t3");

    // early code_valid in WAIT_CNT is ignored
    snap();
    req0 = 1'b1;
    wait_grant(id);
    req0 = 1'b0;
    send(0, 100);
    code_valid = 1'b1; tick(1); code_valid = 1'b0;
    tick(5);
    chk("t4_no_done_a", done_cnt - done_b, 0);
    chk("t4_busy", {31'b0, busy}, 1);
    CNT_valid = 1'b1; tick(1); CNT_valid = 1'b0;
    tick(3);
    chk("t4_no_done_b", done_cnt - done_b, 0);
    code_valid = 1'b1; tick(1); code_valid = 1'b0;
    wait_done(0, "t4");
    frame_checks("t4");

    // reset at symbol 50, then a fresh frame
    req0 = 1'b1;
    wait_grant(id);
    send(0, 50);
    reset = 1'b1;
    #1;
    chk("t5_gnt0", {31'b0, gnt0}, 0);
    chk("t5_gray_valid", {31'b0, gray_valid}, 0);
    chk("t5_core_rst", {31'b0, core_rst}, 1);
    chk("t5_busy", {31'b0, busy}, 0);
    tick(2);
    snap();
    reset = 1'b0;
    wait_grant(id);
    chk("t5_regrant", id, 0);
    req0 = 1'b0;
    send(0, 100);
    finish_frame(0, "t5");
    frame_checks("t5");

    // status withheld after a frame from requester 1
    snap();
    req1 = 1'b1;
    wait_grant(id);
    req1 = 1'b0;
    send(1, 100);
`ifdef HUF_TIMEOUT_EN
    k = 0; found = 1'b0;
    while (!found && k < 400) begin
      tick(1);
      k++;
      if (err) found = 1'b1;
    end
    chk("t6_err_delay", k, 255);
    chk("t6_err_id", {31'b0, done_id}, 1);
    chk("t6_err_idle", {31'b0, busy}, 0);
    tick(1);
    chk("t6_err_pulse", {31'b0, err}, 0);
    chk("t6_err_cnt", err_cnt - err_b, 1);
    chk("t6_no_done", done_cnt - done_b, 0);
    snap();
    req0 = 1'b1;
    wait_grant(id);
    chk("t6b_gnt0", id, 0);
    req0 = 1'b0;
    send(0, 100);
    finish_frame(0, "t6b");
    frame_checks("t6b");
`else
    k = 0; found = 1'b0;
    tick(300);
    chk("t6_no_err", err_cnt - err_b, 0);
    chk("t6_still_busy", {31'b0, busy}, 1);
    chk("t6_no_done", done_cnt - done_b, 0);
    finish_frame(1, "t6");
    frame_checks("t6");
`endif

    chk("no_dual_grant", both_gnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
